// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the sequential slice adder.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of slices needed to cover the full operand width.
   function automatic int nchunk(input int bit_width, input int chunk_width);
      return bit_width / chunk_width;
   endfunction

   // Slice index width; a single-slice build still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/adder_seq_nbit_if.sv
// Request/result bundle between a client and the sequential slice adder.
interface adder_seq_nbit_if #(
   parameter int BIT_WIDTH = 16
);
   logic                 start;
   logic [BIT_WIDTH-1:0] a;
   logic [BIT_WIDTH-1:0] b;
   logic                 carry_in;
   logic                 sub;
   logic                 busy;
   logic                 done;
   logic [BIT_WIDTH-1:0] sum;
   logic                 carry_out;
   logic                 overflow;

   modport master (
      output start, a, b, carry_in, sub,
      input  busy, done, sum, carry_out, overflow
   );

   modport slave (
      input  start, a, b, carry_in, sub,
      output busy, done, sum, carry_out, overflow
   );
endinterface

// File: rtl/adder_nbit.sv
// Combinational unsigned adder; the overflow output is the carry out of the MSB.
module adder_nbit #(
   parameter int BIT_WIDTH = 8
) (
   input  logic [BIT_WIDTH-1:0] a,
   input  logic [BIT_WIDTH-1:0] b,
   input  logic                 carry_in,
   output logic [BIT_WIDTH-1:0] sum,
   output logic                 overflow
);

   // One extra bit of headroom captures the carry out.
   assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, carry_in};

endmodule

// File: rtl/adder_seq_nbit.sv
// Multi-cycle add/subtract: one CHUNK_WIDTH slice per clock through a narrow
// adder, LSB slice first. BIT_WIDTH must be a multiple of CHUNK_WIDTH.
module adder_seq_nbit
   import adder_pkg::*;
#(
   parameter int BIT_WIDTH   = 16,
   parameter int CHUNK_WIDTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   adder_seq_nbit_if.slave bus
);

   localparam int NCHUNK = nchunk(BIT_WIDTH, CHUNK_WIDTH);
   localparam int IDX_W  = idx_width(NCHUNK);
   localparam int MSB    = BIT_WIDTH - 1;

   state_t                 state_q, state_nxt;
   logic                   load;

   logic [BIT_WIDTH-1:0]   a_q, b_q, acc_q, acc_nxt;
   logic                   carry_q;
   logic [IDX_W-1:0]       idx_q;
   logic                   last_slice;

   logic [CHUNK_WIDTH-1:0] a_slice, b_slice, slice_sum;
   logic                   slice_carry;
   logic                   ovf_nxt;

   logic [BIT_WIDTH-1:0]   sum_q;
   logic                   carry_out_q, overflow_q;

   assign last_slice = (idx_q == IDX_W'(NCHUNK - 1));

   // Select the operand slice addressed by the current index.
   always_comb begin
      a_slice = '0;
      b_slice = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (idx_q == IDX_W'(i)) begin
            a_slice = a_q[i*CHUNK_WIDTH +: CHUNK_WIDTH];
            b_slice = b_q[i*CHUNK_WIDTH +: CHUNK_WIDTH];
         end
      end
   end

   adder_nbit #(
      .BIT_WIDTH (CHUNK_WIDTH)
   ) u_slice_adder (
      .a        (a_slice),
      .b        (b_slice),
      .carry_in (carry_q),
      .sum      (slice_sum),
      .overflow (slice_carry)
   );

   // Merge the fresh slice result into the accumulator at the current index.
   always_comb begin
      acc_nxt = acc_q;
      for (int i = 0; i < NCHUNK; i++) begin
         if (idx_q == IDX_W'(i)) begin
            acc_nxt[i*CHUNK_WIDTH +: CHUNK_WIDTH] = slice_sum;
         end
      end
   end

   // Signed overflow: like-signed operands producing a result of the other sign.
   // b_q already holds the inverted operand in subtract mode.
   assign ovf_nxt = (a_q[MSB] == b_q[MSB]) && (acc_nxt[MSB] != a_q[MSB]);

   // Next-state logic; a request is taken in IDLE and also in DONE for back-to-back use.
   always_comb begin
      state_nxt = state_q;
      load      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last_slice) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (bus.start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Operand latch, slice iteration and result capture on the final slice.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         carry_q     <= 1'b0;
         idx_q       <= '0;
         sum_q       <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else if (load) begin
         // Subtract is folded into the operands: A + ~B + 1.
         a_q     <= bus.a;
         b_q     <= bus.sub ? ~bus.b : bus.b;
         carry_q <= bus.sub ? 1'b1 : bus.carry_in;
         acc_q   <= '0;
         idx_q   <= '0;
      end else if (state_q == RUN) begin
         acc_q   <= acc_nxt;
         carry_q <= slice_carry;
         idx_q   <= last_slice ? '0 : idx_q + IDX_W'(1);
         if (last_slice) begin
            sum_q       <= acc_nxt;
            carry_out_q <= slice_carry;
            overflow_q  <= ovf_nxt;
         end
      end
   end

   assign bus.busy      = (state_q == RUN);
   assign bus.done      = (state_q == DONE);
   assign bus.sum       = sum_q;
   assign bus.carry_out = carry_out_q;
   assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_adder_seq_nbit.sv
// Bench for adder_seq_nbit (16-bit operands, 4-bit slices).
module tb_adder_seq_nbit;

   localparam int BW = 16;
   localparam int NCH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   adder_seq_nbit_if #(.BIT_WIDTH(BW)) bus();

   adder_seq_nbit #(
      .BIT_WIDTH   (BW),
      .CHUNK_WIDTH (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string       name;
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sb;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   task automatic model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sb, output logic [15:0] s, output logic co,
                        output logic ov);
      int ua, ub, sa, sbv, t, r;
      ua  = int'(a);
      ub  = int'(b);
      sa  = int'($signed(a));
      sbv = int'($signed(b));
      if (sb) begin
         t  = ua - ub;
         co = (ua >= ub);
         r  = sa - sbv;
      end else begin
         t  = ua + ub + int'(cin);
         co = (t > 65535);
         r  = sa + sbv + int'(cin);
      end
      s  = t[15:0];
      ov = (r > 32767) || (r < -32768);
   endtask

   // Issue one operation, check handshake timing, return the results at done.
   task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sb, output logic [15:0] s,
                        output logic co, output logic ov);
      int n;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.a        = a;
      bus.b        = b;
      bus.carry_in = cin;
      bus.sub      = sb;
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.a        = 16'($urandom);
      bus.b        = 16'($urandom);
      bus.carry_in = 1'($urandom);
      bus.sub      = 1'($urandom);
      check({tag, " busy_after_accept"}, {31'b0, bus.busy}, 32'd1);
      n = 0;
      while (!bus.done && n < 20) begin
         if (!bus.busy) begin
            check({tag, " busy_held"}, {31'b0, bus.busy}, 32'd1);
         end
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, " latency"}, n, NCH);
      check({tag, " busy_at_done"}, {31'b0, bus.busy}, 32'd0);
      s  = bus.sum;
      co = bus.carry_out;
      ov = bus.overflow;
   endtask

   initial begin
      logic [15:0] s, es;
      logic        co, ov, eco, eov;
      logic [15:0] ra, rb;
      logic        rc, rs;
      logic        seen_done;
      int          n;

      vecs[0] = '{"add_basic",  16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
      vecs[1] = '{"add_ripple", 16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0};
      vecs[2] = '{"add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[3] = '{"add_povf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[4] = '{"add_novf",   16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1};
      vecs[5] = '{"sub_neg",    16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[6] = '{"sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};

      bus.start    = 1'b0;
      bus.a        = '0;
      bus.b        = '0;
      bus.carry_in = 1'b0;
      bus.sub      = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset busy", {31'b0, bus.busy}, 32'd0);
      check("reset done", {31'b0, bus.done}, 32'd0);
      check("reset sum", {16'b0, bus.sum}, 32'd0);
      check("reset carry_out", {31'b0, bus.carry_out}, 32'd0);
      check("reset overflow", {31'b0, bus.overflow}, 32'd0);

      // Directed vectors
      for (int i = 0; i < 7; i++) begin
         do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sb, s, co, ov);
         check({vecs[i].name, " sum"}, {16'b0, s}, {16'b0, vecs[i].sum});
         check({vecs[i].name, " carry_out"}, {31'b0, co}, {31'b0, vecs[i].cout});
         check({vecs[i].name, " overflow"}, {31'b0, ov}, {31'b0, vecs[i].ovf});
         @(posedge clk);
         #1;
         check({vecs[i].name, " done_drops"}, {31'b0, bus.done}, 32'd0);
      end

      // Random operations against the model
      for (int i = 0; i < 40; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         rs = 1'($urandom);
         if (i % 8 == 0) rb = 16'h8000;
         if (i % 8 == 1) ra = 16'h7FFF;
         model(ra, rb, rc, rs, es, eco, eov);
         do_op("rand", ra, rb, rc, rs, s, co, ov);
         check("rand sum", {16'b0, s}, {16'b0, es});
         check("rand carry_out", {31'b0, co}, {31'b0, eco});
         check("rand overflow", {31'b0, ov}, {31'b0, eov});
      end

      // start held through RUN with other operands, then accepted in DONE
      @(negedge clk);
      bus.start    = 1'b1;
      bus.a        = 16'h1234;
      bus.b        = 16'h1111;
      bus.carry_in = 1'b0;
      bus.sub      = 1'b0;
      @(posedge clk);
      #1;
      bus.a = 16'h0001;
      bus.b = 16'h0002;
      n = 0;
      while (!bus.done && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("b2b first latency", n, NCH);
      check("b2b first sum", {16'b0, bus.sum}, 32'h2345);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("b2b reaccept busy", {31'b0, bus.busy}, 32'd1);
      check("b2b reaccept done", {31'b0, bus.done}, 32'd0);
      check("b2b sum held", {16'b0, bus.sum}, 32'h2345);
      n = 0;
      while (!bus.done && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("b2b second latency", n, NCH);
      check("b2b second sum", {16'b0, bus.sum}, 32'h0003);

      // Asynchronous reset in the middle of RUN
      @(negedge clk);
      bus.start    = 1'b1;
      bus.a        = 16'h0F0F;
      bus.b        = 16'h0101;
      bus.carry_in = 1'b0;
      bus.sub      = 1'b0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("rst_mid busy", {31'b0, bus.busy}, 32'd0);
      check("rst_mid done", {31'b0, bus.done}, 32'd0);
      check("rst_mid sum", {16'b0, bus.sum}, 32'd0);
      check("rst_mid carry_out", {31'b0, bus.carry_out}, 32'd0);
      check("rst_mid overflow", {31'b0, bus.overflow}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         seen_done = seen_done | bus.done;
      end
      check("rst_mid no_done", {31'b0, seen_done}, 32'd0);
      do_op("after_rst", 16'h0F0F, 16'h0101, 1'b0, 1'b0, s, co, ov);
      check("after_rst sum", {16'b0, s}, 32'h1010);
      check("after_rst carry_out", {31'b0, co}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
